// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch in flight, fixed latency, response held until accepted.
// Word-addressed array with a side load port; bad PCs return a NOP with the error flag set.
module imem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_instr,
  output logic                  rsp_err,
  input  logic                  rsp_ready,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic                  busy
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN     = 33'd4 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [31:0] mem [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_instr_q, rsp_instr_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0]           offset;
  logic                  addr_err;
  logic [DEPTH_LOG2-1:0] idx;

  // Below-base is caught explicitly; the subtraction may wrap but is then ignored.
  assign offset   = addr_q - BASE_ADDR;
  assign addr_err = (addr_q[1:0] != 2'b00) | (addr_q < BASE_ADDR) | ({1'b0, offset} >= SPAN);
  assign idx      = offset[DEPTH_LOG2+1:2];

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    // NOTE: every next-state variable gets a default first, so no latch can be inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = addr_err;
          rsp_instr_d = addr_err ? 32'h0000_0000 : mem[idx];
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // NOTE: the array has no reset; the program survives a reset, and a capture at the
  // same edge as a write sees the old word.
  always_ff @(posedge clk) begin
    if (reset && load_en) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Randomized self-checking bench for imem_responder against a word-array reference model.
// A second instance built with LATENCY=1 covers the single-cycle build.
module tb_imem_responder;

  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam int unsigned WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, rsp_valid, rsp_err, rsp_ready, load_en, busy;
  logic [31:0] req_addr, rsp_instr, load_data;
  logic [9:0]  load_addr;
  logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_err_b, rsp_ready_b, load_en_b, busy_b;
  logic [31:0] req_addr_b, rsp_instr_b, load_data_b;
  logic [9:0]  load_addr_b;

  logic [31:0] model_mem [WORDS];
  logic [31:0] model_b [8];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy));

  imem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_addr(req_addr_b), .req_ready(req_ready_b),
    .rsp_valid(rsp_valid_b), .rsp_instr(rsp_instr_b), .rsp_err(rsp_err_b), .rsp_ready(rsp_ready_b),
    .load_en(load_en_b), .load_addr(load_addr_b), .load_data(load_data_b), .busy(busy_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a fetch is good only if word-aligned and inside [BASE, BASE + 4*WORDS).
  function automatic void ref_fetch(input logic [31:0] a, output logic [31:0] ins, output logic e);
    longint unsigned au = longint'(a);
    if ((au % 4) != 0 || au < longint'(BASE) || au >= longint'(BASE) + 4 * WORDS) begin
      e = 1'b1;
      ins = 32'h0;
    end else begin
      e = 1'b0;
      ins = model_mem[(au - longint'(BASE)) / 4];
    end
  endfunction

  task automatic load_word(input int idx, input logic [31:0] data);
    load_en = 1'b1;
    load_addr = 10'(idx);
    load_data = data;
    tick();
    load_en = 1'b0;
    model_mem[idx] = data;
  endtask

  // One complete fetch: handshake, wait (bounded), optional stall, then accept.
  task automatic fetch(input logic [31:0] a, input int stall, output int lat,
                       output logic [31:0] ins, output logic e, output bit stable,
                       output logic ready_after);
    req_valid = 1'b1;
    req_addr = a;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    req_addr = $urandom;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    ins = rsp_instr;
    e = rsp_err;
    stable = 1'b1;
    repeat (stall) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_instr !== ins || rsp_err !== e) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    ready_after = req_ready & ~rsp_valid;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_instr !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_instr: got %h want 0", rsp_instr); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    n_cmp++; if (rsp_valid_b !== 1'b0 || req_ready_b !== 1'b1) begin
      n_fail++; $display("FAIL reset_l1: got valid=%b ready=%b want 0/1", rsp_valid_b, req_ready_b);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat; logic [31:0] ins; logic e; bit st; logic rdy;
    load_word(0, 32'h2008_0005);
    load_word(1, 32'h3C01_ABCD);
    fetch(32'h0000_3004, 0, lat, ins, e, st, rdy);
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", lat); end
    n_cmp++; if (ins !== 32'h3C01_ABCD) begin n_fail++; $display("FAIL basic_instr: got %h want 3c01abcd", ins); end
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", e); end
    n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after: got %b want 1", rdy); end
  endtask

  task automatic test_hold();
    int lat; logic [31:0] exp_ins; logic exp_e;
    ref_fetch(32'h0000_3000, exp_ins, exp_e);
    req_valid = 1'b1; req_addr = 32'h0000_3000; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL hold_latency: got %0d want 2", lat); end
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_addr = 32'h0000_3004;
      load_en = (i == 2);
      load_addr = 10'd0;
      load_data = 32'hDEAD_BEEF;
      tick();
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_instr !== exp_ins || rsp_err !== exp_e) begin
        n_fail++; $display("FAIL hold_stable[%0d]: got v=%b %h e=%b want 1 %h %b", i, rsp_valid, rsp_instr, rsp_err, exp_ins, exp_e);
      end
      n_cmp++; if (req_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL hold_ready[%0d]: got ready=%b busy=%b want 0/1", i, req_ready, busy);
      end
    end
    load_en = 1'b0;
    model_mem[0] = 32'hDEAD_BEEF;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_release: got valid=%b ready=%b want 0/1", rsp_valid, req_ready);
    end
    repeat (4) tick();
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_ignored_req: got valid=%b busy=%b want 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3];
    int lat; logic [31:0] ins, exp_ins; logic e, exp_e; bit st; logic rdy;
    addrs[0] = 32'h0000_3002; addrs[1] = 32'h0000_2FFC; addrs[2] = 32'h0000_4000;
    for (int i = 0; i < 3; i++) begin
      ref_fetch(addrs[i], exp_ins, exp_e);
      fetch(addrs[i], 1, lat, ins, e, st, rdy);
      n_cmp++; if (e !== exp_e || ins !== exp_ins || lat != 2) begin
        n_fail++; $display("FAIL err_addr %h: got err=%b instr=%h lat=%0d want %b %h 2", addrs[i], e, ins, lat, exp_e, exp_ins);
      end
    end
  endtask

  task automatic test_read_before_write();
    int lat; logic [31:0] ins; logic e; bit st; logic rdy;
    load_word(5, 32'h1111_1111);
    req_valid = 1'b1; req_addr = 32'h0000_3014; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    load_en = 1'b1; load_addr = 10'd5; load_data = 32'h2222_2222;
    tick();
    load_en = 1'b0;
    tick();
    model_mem[5] = 32'h2222_2222;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h2222_2222) begin
      n_fail++; $display("FAIL rbw_early_write: got v=%b %h want 1 22222222", rsp_valid, rsp_instr);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    load_word(5, 32'h1111_1111);
    req_valid = 1'b1; req_addr = 32'h0000_3014;
    tick();
    req_valid = 1'b0;
    tick();
    load_en = 1'b1; load_addr = 10'd5; load_data = 32'h2222_2222;
    tick();
    load_en = 1'b0;
    model_mem[5] = 32'h2222_2222;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h1111_1111) begin
      n_fail++; $display("FAIL rbw_capture_write: got v=%b %h want 1 11111111", rsp_valid, rsp_instr);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    fetch(32'h0000_3014, 0, lat, ins, e, st, rdy);
    n_cmp++; if (ins !== model_mem[5]) begin n_fail++; $display("FAIL rbw_refetch: got %h want %h", ins, model_mem[5]); end
  endtask

  task automatic test_reset_inflight();
    int lat; logic [31:0] ins, exp_ins; logic e, exp_e; bit st; logic rdy; bit seen;
    load_word(7, 32'hA5A5_A5A5);
    seen = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0000_301C; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    reset = 1'b0;
    load_en = 1'b1; load_addr = 10'd7; load_data = 32'h1234_5678;
    tick();
    if (rsp_valid === 1'b1) seen = 1'b1;
    load_en = 1'b0;
    tick();
    if (rsp_valid === 1'b1) seen = 1'b1;
    reset = 1'b1;
    repeat (4) begin tick(); if (rsp_valid === 1'b1) seen = 1'b1; end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL inflight_dropped: got rsp_valid=1 want never"); end
    n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_instr !== 32'h0) begin
      n_fail++; $display("FAIL inflight_idle: got ready=%b busy=%b instr=%h want 1/0/0", req_ready, busy, rsp_instr);
    end
    ref_fetch(32'h0000_301C, exp_ins, exp_e);
    fetch(32'h0000_301C, 0, lat, ins, e, st, rdy);
    n_cmp++; if (ins !== exp_ins || e !== exp_e) begin
      n_fail++; $display("FAIL inflight_mem_kept: got %h err=%b want %h %b", ins, e, exp_ins, exp_e);
    end
  endtask

  task automatic test_random();
    int lat, stall; logic [31:0] a, ins, exp_ins; logic e, exp_e; bit st; logic rdy;
    for (int i = 0; i < 64; i++) load_word(i, $urandom);
    load_word(1023, $urandom);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) load_word($urandom_range(0, 63), $urandom);
      case ($urandom_range(0, 6))
        0, 1, 2: a = BASE + 32'(4 * $urandom_range(0, 63));
        3:       a = BASE + 32'h0000_0FFC;
        4:       a = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
        5:       a = 32'($urandom_range(0, 32'h0000_2FFF));
        default: a = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : BASE + 32'h0000_1000 + ($urandom & 32'h00FF_FFFC);
      endcase
      stall = $urandom_range(0, 3);
      ref_fetch(a, exp_ins, exp_e);
      fetch(a, stall, lat, ins, e, st, rdy);
      n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL rand_latency %h: got %0d want 2", a, lat); end
      n_cmp++; if (ins !== exp_ins || e !== exp_e) begin
        n_fail++; $display("FAIL rand_data %h: got %h err=%b want %h %b", a, ins, e, exp_ins, exp_e);
      end
      n_cmp++; if (!st) begin n_fail++; $display("FAIL rand_stall_stable %h: got unstable want stable", a); end
      n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL rand_ready_after %h: got %b want 1", a, rdy); end
    end
  endtask

  task automatic test_latency1();
    for (int i = 0; i < 8; i++) begin
      model_b[i] = $urandom;
      load_en_b = 1'b1; load_addr_b = 10'(i); load_data_b = model_b[i];
      tick();
    end
    load_en_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_valid_b = 1'b1; req_addr_b = BASE + 32'(4 * i); rsp_ready_b = 1'b1;
      tick();
      req_valid_b = 1'b0;
      n_cmp++; if (rsp_valid_b !== 1'b0) begin n_fail++; $display("FAIL l1_early[%0d]: got 1 want 0", i); end
      tick();
      n_cmp++; if (rsp_valid_b !== 1'b1 || rsp_instr_b !== model_b[i] || rsp_err_b !== 1'b0) begin
        n_fail++; $display("FAIL l1_rsp[%0d]: got v=%b %h e=%b want 1 %h 0", i, rsp_valid_b, rsp_instr_b, rsp_err_b, model_b[i]);
      end
      tick();
      n_cmp++; if (req_ready_b !== 1'b1 || rsp_valid_b !== 1'b0) begin
        n_fail++; $display("FAIL l1_ready[%0d]: got ready=%b valid=%b want 1/0", i, req_ready_b, rsp_valid_b);
      end
    end
    rsp_ready_b = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0;
    load_en = 1'b0; load_addr = 10'd0; load_data = 32'h0;
    req_valid_b = 1'b0; req_addr_b = 32'h0; rsp_ready_b = 1'b0;
    load_en_b = 1'b0; load_addr_b = 10'd0; load_data_b = 32'h0;
    test_reset();
    test_basic();
    test_hold();
    test_errors();
    test_read_before_write();
    test_reset_inflight();
    test_random();
    test_latency1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
